clock_time_ctrl: RTL and testbench

Mode and timing controller for the hours/minutes/seconds timekeeping datapath. It generates the one-second enable pulse that drives the seconds counter and runs a set-time state machine driven by two buttons (mode, increment). In set mode it produces increment pulses for the hours or minutes counter, holds seconds cleared, and returns to run mode on button press or inactivity timeout. It sits between the debounced user inputs and the counter chain's enable/clear inputs.

---
 rtl/clock_time_ctrl.sv | 170 +++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - run/set mode controller and one-second enable generator for the time counters
//
// Ports:
//   clock        system clock, all state on the rising edge
//   reset        synchronous active-high reset
//   io_run_en    global timekeeping enable, gates io_sec_en only
//   io_btn_mode  debounced mode button level
//   io_btn_inc   debounced increment button level
//   io_sec_en    one-cycle enable to the seconds counter (combinational from tick)
//   io_sec_clr   holds the seconds counter at zero while a field is being set
//   io_min_inc   registered one-cycle increment pulse to the minutes counter
//   io_hrs_inc   registered one-cycle increment pulse to the hours counter
//   io_mode      current state: 0 RUN, 1 SET_HRS, 2 SET_MIN
//   io_blink     blink phase for the field being set, 0 in RUN
module clock_time_ctrl #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned REPEAT_DIV  = 12500000,
    parameter int unsigned SET_TIMEOUT = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_run_en,
    input  logic       io_btn_mode,
    input  logic       io_btn_inc,
    output logic       io_sec_en,
    output logic       io_sec_clr,
    output logic       io_min_inc,
    output logic       io_hrs_inc,
    output logic [1:0] io_mode,
    output logic       io_blink
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HRS = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] REP_LAST  = 32'(REPEAT_DIV - 1);
    localparam logic [31:0] IDLE_LAST = 32'(SET_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] prescaler;
    logic [31:0] rep_cnt;
    logic [31:0] idle_cnt;
    logic        rep_armed;
    logic        mode_prev;
    logic        inc_prev;
    logic        blink;
    logic        hrs_inc_q;
    logic        min_inc_q;

    logic        tick;
    logic        mode_edge;
    logic        inc_edge;
    logic        in_set;
    logic        timeout;
    logic        state_change;
    logic        rep_hit;
    logic        inc_pulse;

    assign tick      = (prescaler == TICK_LAST);
    assign mode_edge = io_btn_mode & ~mode_prev;
    assign inc_edge  = io_btn_inc & ~inc_prev;
    assign in_set    = (state != ST_RUN);
    // The tick that would bring the idle count up to SET_TIMEOUT ends the set session.
    assign timeout   = in_set & tick & (idle_cnt == IDLE_LAST);

    always_comb begin
        state_next = state;
        io_sec_en  = 1'b0;
        io_sec_clr = 1'b0;
        case (state)
            ST_RUN: begin
                io_sec_en = tick & io_run_en;
                if (mode_edge) begin
                    state_next = ST_SET_HRS;
                end
            end
            ST_SET_HRS: begin
                io_sec_clr = 1'b1;
                if (timeout) begin
                    state_next = ST_RUN;
                end else if (mode_edge) begin
                    state_next = ST_SET_MIN;
                end
            end
            ST_SET_MIN: begin
                io_sec_clr = 1'b1;
                if (timeout || mode_edge) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign state_change = (state_next != state);

    // Repeats only follow a press made in this set state; holding inc across a
    // mode change does not start pulsing in the new field.
    assign rep_hit   = rep_armed & io_btn_inc & (rep_cnt == REP_LAST);
    assign inc_pulse = in_set & ~state_change & (inc_edge | rep_hit);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= '0;
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            idle_cnt  <= '0;
            blink     <= 1'b0;
            hrs_inc_q <= 1'b0;
            min_inc_q <= 1'b0;
            // Loading the live levels keeps a button held through reset from
            // looking like a fresh press.
            mode_prev <= io_btn_mode;
            inc_prev  <= io_btn_inc;
        end else begin
            mode_prev <= io_btn_mode;
            inc_prev  <= io_btn_inc;

            prescaler <= tick ? '0 : prescaler + 32'd1;

            if (!in_set || state_change || !io_btn_inc || inc_edge || rep_hit) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt + 32'd1;
            end

            if (!in_set || state_change || !io_btn_inc) begin
                rep_armed <= 1'b0;
            end else if (inc_edge) begin
                rep_armed <= 1'b1;
            end

            if (!in_set || state_change || mode_edge || inc_edge) begin
                idle_cnt <= '0;
            end else if (tick) begin
                idle_cnt <= idle_cnt + 32'd1;
            end

            if (!in_set || state_change) begin
                blink <= 1'b0;
            end else if (tick) begin
                blink <= ~blink;
            end

            hrs_inc_q <= inc_pulse & (state == ST_SET_HRS);
            min_inc_q <= inc_pulse & (state == ST_SET_MIN);
        end
    end

    assign io_hrs_inc = hrs_inc_q;
    assign io_min_inc = min_inc_q;
    assign io_mode    = state;
    assign io_blink   = blink;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - self-checking bench for clock_time_ctrl
module tb_clock_time_ctrl;

    localparam int TD = 4;
    localparam int RD = 3;
    localparam int ST = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       run_en;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_en;
    logic       sec_clr;
    logic       min_inc;
    logic       hrs_inc;
    logic [1:0] mode;
    logic       blink;

    always #5 clock = ~clock;

    clock_time_ctrl #(
        .TICK_DIV   (TD),
        .REPEAT_DIV (RD),
        .SET_TIMEOUT(ST)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .io_run_en  (run_en),
        .io_btn_mode(btn_mode),
        .io_btn_inc (btn_inc),
        .io_sec_en  (sec_en),
        .io_sec_clr (sec_clr),
        .io_min_inc (min_inc),
        .io_hrs_inc (hrs_inc),
        .io_mode    (mode),
        .io_blink   (blink)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: cycle count since reset, tick from modular arithmetic,
    // auto-repeat from distance to the press that started the hold
    int     m_state;
    longint m_cyc;
    longint m_edge;
    bit     m_pm, m_pi, m_armed, m_blink, m_hrs, m_min;
    int     m_idle;

    logic       s_sec_en, s_sec_clr, s_min, s_hrs, s_blink;
    logic [1:0] s_mode;

    typedef struct {
        bit         m;
        bit         i;
        logic [1:0] e_mode;
        bit         e_clr;
        bit         e_hrs;
        bit         e_min;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input longint c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit m, input bit i, input bit r);
        bit tick, medge, iedge, tout, change, pulse;
        int nstate;
        reset    = rst;
        btn_mode = m;
        btn_inc  = i;
        run_en   = r;
        #1;
        s_sec_en  = sec_en;
        s_sec_clr = sec_clr;
        s_min     = min_inc;
        s_hrs     = hrs_inc;
        s_mode    = mode;
        s_blink   = blink;
        if (rst) begin
            m_state = 0; m_cyc = 0; m_pm = m; m_pi = i; m_idle = 0;
            m_blink = 0; m_hrs = 0; m_min = 0; m_armed = 0; m_edge = 0;
        end else begin
            tick = ((m_cyc % TD) == TD - 1);
            chk("model_sec_en", m_cyc, {31'd0, s_sec_en}, {31'd0, (m_state == 0) && r && tick});
            chk("model_sec_clr", m_cyc, {31'd0, s_sec_clr}, {31'd0, m_state != 0});
            chk("model_hrs_inc", m_cyc, {31'd0, s_hrs}, {31'd0, m_hrs});
            chk("model_min_inc", m_cyc, {31'd0, s_min}, {31'd0, m_min});
            chk("model_mode", m_cyc, {30'd0, s_mode}, m_state);
            chk("model_blink", m_cyc, {31'd0, s_blink}, {31'd0, m_blink});

            medge  = m && !m_pm;
            iedge  = i && !m_pi;
            tout   = (m_state != 0) && tick && (m_idle == ST - 1);
            nstate = medge ? (m_state + 1) % 3 : m_state;
            if (tout) nstate = 0;
            change = (nstate != m_state);
            pulse  = 0;
            if (m_state == 0 || change || !i) begin
                m_armed = 0;
            end else if (iedge) begin
                m_armed = 1;
                m_edge  = m_cyc;
                pulse   = 1;
            end else if (m_armed && ((m_cyc - m_edge) % RD) == 0) begin
                pulse = 1;
            end
            m_hrs = pulse && (m_state == 1);
            m_min = pulse && (m_state == 2);
            if (change || m_state == 0 || medge || iedge) m_idle = 0;
            else if (tick) m_idle++;
            if (change || m_state == 0) m_blink = 0;
            else if (tick) m_blink = !m_blink;
            m_state = nstate;
            m_pm    = m;
            m_pi    = i;
            m_cyc++;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset(input bit m, input bit i);
        step(1, m, i, 0);
        step(1, m, i, 0);
    endtask

    initial begin
        bit rm, ri, rr;
        reset = 1'b1; run_en = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;

        tbl[0]  = '{0, 0, 2'd0, 0, 0, 0};
        tbl[1]  = '{1, 0, 2'd0, 0, 0, 0};
        tbl[2]  = '{1, 0, 2'd1, 1, 0, 0};
        tbl[3]  = '{0, 1, 2'd1, 1, 0, 0};
        tbl[4]  = '{0, 0, 2'd1, 1, 1, 0};
        tbl[5]  = '{0, 0, 2'd1, 1, 0, 0};
        tbl[6]  = '{1, 1, 2'd1, 1, 0, 0};
        tbl[7]  = '{0, 0, 2'd2, 1, 0, 0};
        tbl[8]  = '{0, 1, 2'd2, 1, 0, 0};
        tbl[9]  = '{0, 1, 2'd2, 1, 0, 1};
        tbl[10] = '{0, 0, 2'd2, 1, 0, 0};
        tbl[11] = '{1, 0, 2'd2, 1, 0, 0};
        tbl[12] = '{0, 0, 2'd0, 0, 0, 0};
        tbl[13] = '{0, 1, 2'd0, 0, 0, 0};
        tbl[14] = '{0, 0, 2'd0, 0, 0, 0};

        @(negedge clock);

        // reset state
        do_reset(0, 0);
        step(0, 0, 0, 1);
        chk("rst_mode", 0, {30'd0, s_mode}, 0);
        chk("rst_outs", 0, {27'd0, s_sec_en, s_sec_clr, s_hrs, s_min, s_blink}, 0);

        // tick generation and run_en gating
        do_reset(0, 0);
        for (int c = 0; c < 32; c++) begin
            step(0, 0, 0, (c < 16 || c >= 28));
            if (c < 16 || c >= 28) chk("tick_sec_en", c, {31'd0, s_sec_en}, {31'd0, (c % 4) == 3});
            else chk("gated_sec_en", c, {31'd0, s_sec_en}, 0);
        end

        // table vectors: mode/inc sequencing and mode-vs-inc conflict
        do_reset(0, 0);
        for (int c = 0; c < 15; c++) begin
            step(0, tbl[c].m, tbl[c].i, 0);
            chk("tbl_mode", c, {30'd0, s_mode}, {30'd0, tbl[c].e_mode});
            chk("tbl_clr", c, {31'd0, s_sec_clr}, {31'd0, tbl[c].e_clr});
            chk("tbl_hrs", c, {31'd0, s_hrs}, {31'd0, tbl[c].e_hrs});
            chk("tbl_min", c, {31'd0, s_min}, {31'd0, tbl[c].e_min});
        end

        // mode cycling with edges at 10, 20, 30
        do_reset(0, 0);
        for (int c = 0; c < 35; c++) begin
            step(0, (c == 10 || c == 20 || c == 30), 0, 1);
            chk("cyc_mode", c, {30'd0, s_mode}, (c >= 31) ? 0 : (c >= 21) ? 2 : (c >= 11) ? 1 : 0);
            chk("cyc_clr", c, {31'd0, s_sec_clr}, {31'd0, c >= 11 && c <= 30});
            chk("cyc_sec_en", c, {31'd0, s_sec_en}, {31'd0, (c % 4) == 3 && (c < 11 || c > 30)});
        end

        // single increment in SET_MIN, then SET_HRS
        do_reset(0, 0);
        for (int c = 0; c < 13; c++) begin
            step(0, (c == 1 || c == 4), (c == 7 || c == 8), 1);
            if (c >= 5) begin
                chk("smin_min", c, {31'd0, s_min}, {31'd0, c == 8});
                chk("smin_hrs", c, {31'd0, s_hrs}, 0);
            end
        end
        do_reset(0, 0);
        for (int c = 0; c < 10; c++) begin
            step(0, (c == 1), (c == 4 || c == 5), 1);
            chk("shrs_hrs", c, {31'd0, s_hrs}, {31'd0, c == 5});
            chk("shrs_min", c, {31'd0, s_min}, 0);
        end

        // auto-repeat: held 10 cycles from cycle 6
        do_reset(0, 0);
        for (int c = 0; c < 21; c++) begin
            step(0, (c == 1), (c >= 6 && c <= 15), 1);
            chk("rep_hrs", c, {31'd0, s_hrs}, {31'd0, c == 7 || c == 10 || c == 13 || c == 16});
        end

        // timeout with blink, no buttons
        do_reset(0, 0);
        for (int c = 0; c < 21; c++) begin
            step(0, (c == 1), 0, 1);
            chk("to_mode", c, {30'd0, s_mode}, (c >= 2 && c <= 15) ? 1 : 0);
            chk("to_blink", c, {31'd0, s_blink}, {31'd0, (c >= 4 && c <= 7) || (c >= 12 && c <= 15)});
        end

        // timeout restarted by an inc edge after the first tick
        do_reset(0, 0);
        for (int c = 0; c < 23; c++) begin
            step(0, (c == 1), (c == 5), 1);
            chk("tor_mode", c, {30'd0, s_mode}, (c >= 2 && c <= 19) ? 1 : 0);
            chk("tor_hrs", c, {31'd0, s_hrs}, {31'd0, c == 6});
            chk("tor_blink", c, {31'd0, s_blink}, {31'd0, (c >= 4 && c <= 7) || (c >= 12 && c <= 15)});
        end

        // reset during auto-repeat, buttons held across reset
        do_reset(0, 0);
        for (int c = 0; c < 7; c++) begin
            step(0, (c == 1), (c >= 4), 0);
            if (c == 5) chk("abort_first", c, {31'd0, s_hrs}, 1);
        end
        step(1, 1, 1, 0);
        for (int c = 0; c < 10; c++) begin
            step(0, (c < 8), (c < 8), 0);
            chk("abort_mode", c, {30'd0, s_mode}, 0);
            chk("abort_outs", c, {27'd0, s_sec_en, s_sec_clr, s_hrs, s_min, s_blink}, 0);
        end

        // randomized buttons and enables against the model
        do_reset(0, 0);
        rm = 0; ri = 0; rr = 1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 15) == 0) rm = !rm;
            if ($urandom_range(0, 11) == 0) ri = !ri;
            if ($urandom_range(0, 63) == 0) rr = !rr;
            step(($urandom_range(0, 999) == 0), rm, ri, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
